// File: rtl/mem_wb_reg_pkg.sv
// Shared constants for the MEM/WB pipeline register and the LL/SC reservation logic.
package mem_wb_reg_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int RADDR_W_DEF = 5;

  // Lowest address bit that takes part in the linked-word compare (word granule).
  localparam int LL_LINK_LSB = 2;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_wb_reg_llbit_reg.sv
// LL/SC reservation bit with optional linked-word snoop (enabled by LLBIT_SNOOP_EN).
module llbit_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_i,
  input  logic              flush_i,
  input  logic              wbit_i,
  input  logic              wllbit_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic              mem_wr_i,
  output logic              llbit_o
);

  logic llbit_q, llbit_d;
  logic snoop_hit;

`ifdef LLBIT_SNOOP_EN
  logic [DATA_W-1:0] link_addr_q, link_addr_d;

  assign snoop_hit = mem_wr_i &&
    (mem_addr_i[DATA_W-1:LL_LINK_LSB] == link_addr_q[DATA_W-1:LL_LINK_LSB]);

  always_comb begin
    link_addr_d = link_addr_q;
    if (commit_i && wbit_i && wllbit_i) begin
      link_addr_d = mem_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      link_addr_q <= '0;
    end else begin
      link_addr_q <= link_addr_d;
    end
  end
`else
  logic unused_snoop;
  assign unused_snoop = ^{mem_addr_i, mem_wr_i};
  assign snoop_hit    = 1'b0;
`endif

  // A squash always breaks the reservation; a successful Sc/Ll write beats the snoop.
  always_comb begin
    // NOTE: default-assign first so every path drives llbit_d and no latch is inferred.
    llbit_d = llbit_q;
    if (flush_i) begin
      llbit_d = 1'b0;
    end else if (commit_i) begin
      if (wbit_i) begin
        llbit_d = wllbit_i;
      end else if (snoop_hit) begin
        llbit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      llbit_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      llbit_q <= llbit_d;
    end
  end

  assign llbit_o = llbit_q;

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register plus LL/SC reservation state; word snoop enabled by LLBIT_SNOOP_EN.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [RADDR_W-1:0] regAddr_i,
  input  logic               regWr_i,
  input  logic [DATA_W-1:0]  regData_i,
  input  logic               wLLbit_i,
  input  logic               wbit_i,
  input  logic [DATA_W-1:0]  memAddr_i,
  input  logic               memWr_i,
  output logic [RADDR_W-1:0] regAddr_o,
  output logic               regWr_o,
  output logic [DATA_W-1:0]  regData_o,
  output logic               rLLbit
);

  logic               commit;
  logic [RADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic               reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0]  reg_data_q, reg_data_d;

  assign commit = (rst != RST_ENABLE) && !stall && !flush;

  // Anything that is not a commit loads a bubble.
  always_comb begin
    reg_addr_d = '0;
    reg_wr_d   = WRITE_DISABLE;
    reg_data_d = '0;
    if (commit) begin
      reg_addr_d = regAddr_i;
      reg_wr_d   = regWr_i;
      reg_data_d = regData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      reg_addr_q <= '0;
      reg_wr_q   <= WRITE_DISABLE;
      reg_data_q <= '0;
    end else begin
      reg_addr_q <= reg_addr_d;
      reg_wr_q   <= reg_wr_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign regAddr_o = reg_addr_q;
  assign regWr_o   = reg_wr_q;
  assign regData_o = reg_data_q;

  llbit_reg #(
    .DATA_W(DATA_W)
  ) u_llbit_reg (
    .clk       (clk),
    .rst       (rst),
    .commit_i  (commit),
    .flush_i   (flush),
    .wbit_i    (wbit_i),
    .wllbit_i  (wLLbit_i),
    .mem_addr_i(memAddr_i),
    .mem_wr_i  (memWr_i),
    .llbit_o   (rLLbit)
  );

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: directed scenarios plus random traffic against a reference model.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic        reg_wr = 1'b0;
  logic [31:0] reg_data = '0;
  logic        wllbit = 1'b0;
  logic        wbit = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_wr = 1'b0;
  logic [4:0]  reg_addr_o;
  logic        reg_wr_o;
  logic [31:0] reg_data_o;
  logic        rllbit;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic        ll;
  } exp_t;

  exp_t sb[$];

  mem_wb_reg dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .regAddr_i(reg_addr),
    .regWr_i  (reg_wr),
    .regData_i(reg_data),
    .wLLbit_i (wllbit),
    .wbit_i   (wbit),
    .memAddr_i(mem_addr),
    .memWr_i  (mem_wr),
    .regAddr_o(reg_addr_o),
    .regWr_o  (reg_wr_o),
    .regData_o(reg_data_o),
    .rLLbit   (rllbit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the write-back stage and reservation should look like after each edge.
  logic        m_ll = 1'b0;
  logic [31:0] m_link = '0;
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      e = '{addr: '0, wr: 1'b0, data: '0, ll: 1'b0};
      m_ll = 1'b0;
      m_link = '0;
    end else begin
      if (!stall && !flush) e = '{addr: reg_addr, wr: reg_wr, data: reg_data, ll: 1'b0};
      else                  e = '{addr: '0, wr: 1'b0, data: '0, ll: 1'b0};
      if (flush) m_ll = 1'b0;
      else if (!stall) begin
        if (wbit) begin
          m_ll = wllbit;
          if (wllbit) m_link = mem_addr;
        end
`ifdef LLBIT_SNOOP_EN
        else if (mem_wr && (mem_addr / 4) == (m_link / 4)) m_ll = 1'b0;
`endif
      end
      e.ll = m_ll;
    end
    sb.push_back(e);
  end

  // Monitor: compares the DUT outputs against the oldest expectation, away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_regAddr", 32'(reg_addr_o), 32'(e.addr));
      check("sb_regWr",   32'(reg_wr_o),   32'(e.wr));
      check("sb_regData", reg_data_o,      e.data);
      check("sb_rLLbit",  32'(rllbit),     32'(e.ll));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic [4:0] a, input logic w, input logic [31:0] d,
                     input logic wb, input logic wl, input logic [31:0] ma, input logic mw);
    @(negedge clk);
    rst = r; stall = s; flush = f;
    reg_addr = a; reg_wr = w; reg_data = d;
    wbit = wb; wllbit = wl; mem_addr = ma; mem_wr = mw;
  endtask

  // Sample the result of the inputs applied by the preceding cyc call.
  task automatic expect_after(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    @(posedge clk);
    #1;
    case (act_sel)
      0: check(name, 32'(rllbit), exp);
      1: check(name, 32'(reg_wr_o), exp);
      2: check(name, 32'(reg_addr_o), exp);
      default: check(name, reg_data_o, exp);
    endcase
  endtask

  localparam logic [31:0] SEL_LL = 0, SEL_WR = 1, SEL_ADDR = 2, SEL_DATA = 3;

  task automatic ll_at(input logic [31:0] ma);
    cyc(0, 0, 0, 5'd0, 0, 32'h0, 1, 1, ma, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a live write request on the inputs.
    cyc(1, 0, 0, 5'd3, 1, 32'hDEADBEEF, 1, 1, 32'h100, 0);
    expect_after("rst_regWr", SEL_WR, 0);
    check("rst_regData", reg_data_o, 32'h0);
    check("rst_rLLbit", 32'(rllbit), 0);
    cyc(1, 0, 0, 5'd3, 1, 32'hDEADBEEF, 1, 1, 32'h100, 0);

    // Pass-through, then stall bubble.
    cyc(0, 0, 0, 5'd9, 1, 32'h1234_5678, 0, 0, 32'h0, 0);
    expect_after("pass_regAddr", SEL_ADDR, 9);
    check("pass_regWr", 32'(reg_wr_o), 1);
    check("pass_regData", reg_data_o, 32'h1234_5678);
    cyc(0, 1, 0, 5'd9, 1, 32'h1234_5678, 0, 0, 32'h0, 0);
    expect_after("stall_bubble_wr", SEL_WR, 0);
    check("stall_bubble_data", reg_data_o, 32'h0);

    // Ll then Sc.
    ll_at(32'h100);
    expect_after("ll_set", SEL_LL, 1);
    cyc(0, 0, 0, 5'd4, 1, 32'h1, 1, 0, 32'h100, 1);
    expect_after("sc_clear", SEL_LL, 0);

    // Flush wins over stall and an LLbit write.
    ll_at(32'h100);
    cyc(0, 1, 1, 5'd7, 1, 32'hAAAA_5555, 1, 1, 32'h200, 0);
    expect_after("flush_ll", SEL_LL, 0);
    check("flush_regWr", 32'(reg_wr_o), 0);

    // Snoop: same word, then a different word.
    ll_at(32'h100);
    cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 32'h102, 1);
`ifdef LLBIT_SNOOP_EN
    expect_after("snoop_same_word", SEL_LL, 0);
`else
    expect_after("snoop_same_word", SEL_LL, 1);
`endif
    ll_at(32'h100);
    cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 32'h104, 1);
    expect_after("snoop_other_word", SEL_LL, 1);

    // Back-to-back Ll: the second one owns the link.
    ll_at(32'h100);
    ll_at(32'h200);
    cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 32'h100, 1);
    expect_after("ll_ll_old_word", SEL_LL, 1);
    cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 32'h200, 1);
`ifdef LLBIT_SNOOP_EN
    expect_after("ll_ll_new_word", SEL_LL, 0);
`else
    expect_after("ll_ll_new_word", SEL_LL, 1);
`endif

    // Stall holds the reservation against a pending Sc.
    ll_at(32'h300);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 5'd2, 1, 32'h5, 1, 0, 32'h300, 1);
      expect_after("stall_hold_ll", SEL_LL, 1);
    end
    cyc(0, 0, 0, 5'd2, 1, 32'h5, 1, 0, 32'h300, 1);
    expect_after("stall_release_ll", SEL_LL, 0);

    // Random traffic over a handful of nearby addresses so snoops hit often.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
          5'($urandom), 1'($urandom), $urandom,
          $urandom_range(0, 2) == 0, 1'($urandom),
          32'h100 + 32'($urandom_range(0, 11)), 1'($urandom));
    end

    cyc(0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
Name: mem_wb_reg

Overview:
- Pipeline register between the memory-access stage and the register-file write-back, plus the processor's LL/SC reservation state.
- Captures the memory stage's write-back triple (regAddr/regWr/regData) and its LLbit update request (wLLbit/wbit) on each clock.
- Feeds the registered triple to the register file and returns the current reservation bit (rLLbit) to the memory stage for Sc evaluation.
- Optionally tracks the linked word address and breaks the reservation on any other store to that word.

Parameters:
- DATA_W, 32, register data width and memory address width
- RADDR_W, 5, register-file address width

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high (`RstEnable = 1)
- stall  input  1  memory stage holding its instruction this cycle; no commit
- flush  input  1  exception/ERET squash of the instruction in the memory stage
- regAddr_i  input  RADDR_W  destination register from memory stage
- regWr_i  input  1  register write enable from memory stage
- regData_i  input  DATA_W  write-back data from memory stage
- wLLbit_i  input  1  new LLbit value requested
- wbit_i  input  1  LLbit write request (Ll, or successful Sc)
- memAddr_i  input  DATA_W  memory address of the instruction in the memory stage
- memWr_i  input  1  memory stage is performing a store
- regAddr_o  output  RADDR_W  registered destination to register file
- regWr_o  output  1  registered write enable
- regData_o  output  DATA_W  registered write data
- rLLbit  output  1  current reservation bit, to memory stage

Behaviour:
Reset and bubbles:
- Reset (rst=1 at edge): regAddr_o=0, regWr_o=0, regData_o=0 (`Zero), llbit=0, linkAddr=0.
- Reset overrides every other input.
- "Commit" this cycle = !rst & !stall & !flush.
- Commit: regAddr_o/regWr_o/regData_o <= inputs at the edge; latency exactly 1 cycle.
- stall=1 (flush=0): outputs load a bubble (regWr_o=0, regAddr_o=0, regData_o=0). llbit and linkAddr hold.
- flush=1: outputs load the bubble and llbit <= 0, regardless of stall. linkAddr holds.

LLbit update on commit, in priority order:
- (a) wbit_i=1: llbit <= wLLbit_i. If wLLbit_i=1, also linkAddr <= memAddr_i.
- (b) snoop clear (feature only).
- (c) otherwise hold.

rLLbit and timing:
- rLLbit = llbit register, no combinational path from inputs.
- Ll committed at edge N is visible to an Sc in the memory stage during cycle N+1; no forwarding is needed.
- Sc with wbit_i=1, wLLbit_i=0 clears llbit at commit.
- A failed Sc has wbit_i=0, so llbit is unchanged.

Edge case:
- Back-to-back Ll, Ll: the second overwrites linkAddr.

Optional Feature:
Macro LLBIT_SNOOP_EN.
- Defined:
  - On commit with memWr_i=1, wbit_i=0 and memAddr_i[DATA_W-1:2]==linkAddr[DATA_W-1:2], llbit <= 0.
  - wbit_i=1 (successful Sc) takes priority over the snoop.
  - Stores to other words leave llbit unchanged.
- Undefined:
  - No linkAddr register; llbit is changed only by wbit_i, flush and rst.
  - memAddr_i and memWr_i are unused.

Decomposition:
- Shared definitions header: `RstEnable, `Zero, `WriteEnable, and the DATA_W/RADDR_W defaults.
- New header constant: LL_LINK_LSB = 2, the word-granule compare bit.
- One natural sub-module: llbit_reg, holding llbit, linkAddr and the priority/snoop logic, with the commit qualifier as input.
- The pipeline register stays in mem_wb_reg.

Test Plan:
- Reset: rst=1 for 2 cycles with regWr_i=1, regData_i=32'hDEADBEEF -> all outputs 0 and rLLbit=0 after the first edge.
- Pass-through: regAddr_i=5'd9, regWr_i=1, regData_i=32'h1234_5678 with no stall/flush -> regAddr_o=9, regWr_o=1, regData_o=32'h12345678 one cycle later; then stall=1 -> bubble on the next cycle.
- Ll then Sc: cycle 0 wbit_i=1, wLLbit_i=1, memAddr_i=32'h100 -> rLLbit=1 in cycle 1; Sc in cycle 1 with wbit_i=1, wLLbit_i=0 -> rLLbit=0 in cycle 2.
- Flush priority: llbit=1, then flush=1 with stall=1 and wbit_i=1, wLLbit_i=1 -> rLLbit=0 and regWr_o=0 next cycle.
- Snoop (LLBIT_SNOOP_EN): Ll at 32'h100, then store memWr_i=1 to 32'h102 -> rLLbit=0; repeat with the store to 32'h104 -> rLLbit stays 1. With the macro undefined, both cases keep rLLbit=1.
- Stall hold: llbit=1, stall=1 with wbit_i=1, wLLbit_i=0 for 3 cycles -> rLLbit stays 1; releasing stall -> rLLbit=0 next cycle.
